// File: rtl/sum_frame_if.sv
// Stream-in / frame-out bundle between a word producer, sum_frame_collector and the sum stage.
// The in_last field is present only when SUM_FRAME_FLUSH_EN is defined.
interface sum_frame_if #(
   parameter int WIDTH = 32,
   parameter int LANES = 8
);
   logic [WIDTH-1:0]       in_data;
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*WIDTH-1:0] out_data;
   logic                   out_valid;
   logic                   out_ready;
`ifdef SUM_FRAME_FLUSH_EN
   logic                   in_last;
`endif

   // Environment side: produces words, consumes frames.
   modport master (
`ifdef SUM_FRAME_FLUSH_EN
      output in_last,
`endif
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   // Collector side.
   modport slave (
`ifdef SUM_FRAME_FLUSH_EN
      input  in_last,
`endif
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/sum_frame_collector.sv
// Packs LANES consecutive WIDTH-bit words into one double-buffered frame for sum_step_1.
// Optional SUM_FRAME_FLUSH_EN: in_last closes a frame early, zero-filling the remaining lanes.
module sum_frame_collector #(
   parameter int WIDTH = 32,
   parameter int LANES = 8
) (
   input  logic        clk,
   input  logic        rst,
   sum_frame_if.slave  bus
);
   localparam int CNT_W = $clog2(LANES);
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]             r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [WIDTH-1:0]       r_buf [LANES];
   logic [LANES*WIDTH-1:0] r_out_data;
   logic                   r_out_valid;

   logic                   w_in_ready;
   logic                   w_in_beat;
   logic                   w_out_beat;
   logic                   w_slot_free;
   logic                   w_last;
   logic                   w_close;
   logic [WIDTH-1:0]       w_frame [LANES];
   logic [LANES*WIDTH-1:0] w_frame_flat;
   logic [LANES*WIDTH-1:0] w_buf_flat;

`ifdef SUM_FRAME_FLUSH_EN
   assign w_last = bus.in_last;
`else
   assign w_last = 1'b0;
`endif

   assign w_in_ready  = !rst && (r_state == ST_FILL);
   assign w_in_beat   = bus.in_valid && w_in_ready;
   assign w_out_beat  = r_out_valid && bus.out_ready;
   assign w_slot_free = !r_out_valid || bus.out_ready;
   assign w_close     = w_in_beat && ((r_cnt == LAST_LANE) || w_last);

   // w_frame is the buffer as it will look after this cycle's beat, so a closing
   // beat can hand off the complete frame, accepted word included, in one step.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign w_frame[gi] = (int'(r_cnt) == gi)           ? bus.in_data :
                              (w_last && (int'(r_cnt) < gi)) ? '0          :
                                                               r_buf[gi];
         assign w_frame_flat[gi*WIDTH +: WIDTH] = w_frame[gi];
         assign w_buf_flat[gi*WIDTH +: WIDTH]   = r_buf[gi];

         always_ff @(posedge clk) begin
            if (rst) begin
               r_buf[gi] <= '0;
            end else if (w_in_beat) begin
               r_buf[gi] <= w_frame[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_FILL;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (w_out_beat) begin
                  r_out_valid <= 1'b0;
               end
               if (w_in_beat) begin
                  if (w_close) begin
                     r_cnt <= '0;
                     if (w_slot_free) begin
                        r_out_data  <= w_frame_flat;
                        r_out_valid <= 1'b1;
                     end else begin
                        r_state <= ST_HOLD;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               // The held frame was completed in the buffer; swap it in as the old one leaves.
               if (w_out_beat) begin
                  r_out_data <= w_buf_flat;
                  r_state    <= ST_FILL;
               end
            end
            default: r_state <= ST_FILL;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_sum_frame_collector.sv
// Scoreboard bench for sum_frame_collector: a word-queue model predicts frames, a monitor checks them.
`timescale 1ns/1ps
module tb_sum_frame_collector;
   localparam int W = 32;
   localparam int L = 8;
   typedef logic [W-1:0]   word_t;
   typedef logic [L*W-1:0] frame_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   pops = 0;
   int   ready_mode = 0;   // 0: hold off, 1: always ready, 2: random

   word_t  cur_q[$];
   frame_t exp_q[$];

   sum_frame_if #(.WIDTH(W), .LANES(L)) bus ();

   sum_frame_collector #(.WIDTH(W), .LANES(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      if (ready_mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
      else                 bus.out_ready = (ready_mode == 1);
   end

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic frame_t pack(input word_t words[$]);
      frame_t f = '0;
      foreach (words[k]) f[k*W +: W] = words[k];
      return f;
   endfunction

   function automatic logic [W-1:0] lane_sum(input frame_t f);
      logic [W-1:0] s = '0;
      for (int k = 0; k < L; k++) s = s + f[k*W +: W];
      return s;
   endfunction

   // Reference model: a frame is whatever words were accepted, closed at L words or in_last.
   task automatic model_accept(input word_t d, input logic last);
      cur_q.push_back(d);
      if (last || cur_q.size() == L) begin
         exp_q.push_back(pack(cur_q));
         cur_q.delete();
      end
   endtask

   task automatic send_word(input word_t d, input logic last);
      bus.in_data  = d;
      bus.in_valid = 1'b1;
`ifdef SUM_FRAME_FLUSH_EN
      bus.in_last  = last;
`endif
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            model_accept(d, last);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
`ifdef SUM_FRAME_FLUSH_EN
            bus.in_last  = 1'b0;
`endif
            return;
         end
         @(posedge clk); #1;
      end
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: got no in_ready expected acceptance of %0h", d);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      ready_mode = 1;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && !bus.out_valid) break;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   // Monitor: pops on each output beat and checks hold stability while stalled.
   frame_t held_data;
   logic   held = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else begin
         if (held) begin
            check("stable_valid", bus.out_valid, 1);
            check("stable_data", bus.out_data, held_data);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL unexpected_frame: got %0h expected none", bus.out_data);
            end else begin
               check("frame", bus.out_data, exp_q.pop_front());
               pops++;
            end
         end
         held      = bus.out_valid && !bus.out_ready;
         held_data = bus.out_data;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, p0;
      frame_t fa, fb, f1;
      word_t  wq[$];

      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
`ifdef SUM_FRAME_FLUSH_EN
      bus.in_last  = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // T1: words 1..8, out_valid one cycle after the 8th beat
      ready_mode = 1;
      for (int i = 1; i <= 8; i++) send_word(word_t'(i), 1'b0);
      f1 = '0;
      for (int i = 0; i < 8; i++) f1[i*W +: W] = word_t'(i + 1);
      check("t1_latency", bus.out_valid, 1);
      check("t1_data", bus.out_data, f1);
      check("t1_sum", lane_sum(bus.out_data), 36);
      drain();

      // T2: 32 back-to-back words, no stall, 4 frames
      c0 = cyc; p0 = pops;
      for (int i = 0; i < 32; i++) send_word($urandom, 1'b0);
      check("t2_no_stall_cycles", cyc - c0, 32);
      repeat (2) begin @(posedge clk); #1; end
      check("t2_frames", pops - p0, 4);
      drain();

      // T3: consumer stalled, frame A held, frame B collected, then handoff
      ready_mode = 0;
      wq.delete();
      for (int i = 0; i < 16; i++) begin
         wq.push_back(word_t'($urandom));
         send_word(wq[i], 1'b0);
      end
      fa = '0; fb = '0;
      for (int i = 0; i < 8; i++) begin
         fa[i*W +: W] = wq[i];
         fb[i*W +: W] = wq[i+8];
      end
      check("t3_in_ready_hold", bus.in_ready, 0);
      check("t3_held_a", bus.out_data, fa);
      ready_mode = 1;
      @(posedge clk); #1;
      ready_mode = 0;
      #2;
      check("t3_frame_b", bus.out_data, fb);
      check("t3_valid_b", bus.out_valid, 1);
      check("t3_in_ready_back", bus.in_ready, 1);
      drain();

      // T4: reset after 5 words discards the partial frame
      for (int i = 0; i < 5; i++) send_word(word_t'(32'h100 + i), 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("t4_in_ready_rst", bus.in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      cur_q.delete();
      exp_q.delete();
      check("t4_out_valid", bus.out_valid, 0);
      check("t4_out_data", bus.out_data, 0);
      for (int i = 0; i < 8; i++) send_word(word_t'(32'h200 + i), 1'b0);
      drain();

      // T5: all-ones words pass unmodified; downstream sum wraps
      for (int i = 0; i < 8; i++) send_word(32'hFFFF_FFFF, 1'b0);
      check("t5_data", bus.out_data, {L{32'hFFFF_FFFF}});
      check("t5_sum", lane_sum(bus.out_data), 32'hFFFF_FFF8);
      drain();

`ifdef SUM_FRAME_FLUSH_EN
      // T6: early close with in_last zero-fills lanes 3..7
      send_word(32'd5, 1'b0);
      send_word(32'd6, 1'b0);
      send_word(32'd7, 1'b1);
      check("t6_valid", bus.out_valid, 1);
      check("t6_data", bus.out_data, {160'd0, 32'd7, 32'd6, 32'd5});
      for (int i = 0; i < 8; i++) send_word(word_t'(32'h300 + i), 1'b0);
      drain();
`endif

      // Randomised traffic: idle gaps, random consumer stalls, random early closes
      ready_mode = 2;
      for (int i = 0; i < 400; i++) begin
         logic last;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
`ifdef SUM_FRAME_FLUSH_EN
         last = ($urandom_range(0, 5) == 0);
`else
         last = 1'b0;
`endif
         send_word($urandom, last);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
